// File: rtl/level_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : level_rom_arbiter
// Description : Round-robin sharing of the level-map ROM between the tile
//               renderer (r_*) and the collision checker (c_*).
// Revision    : 1.0 - initial release
// ============================================================================
module level_rom_arbiter #(
    parameter int NUM_ROWS  = 11,
    parameter int ROW_WIDTH = 10
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 r_req,
    input  logic [3:0]           r_row,
    output logic                 r_gnt,
    output logic                 r_valid,
    output logic [ROW_WIDTH-1:0] r_data,
    output logic                 r_oob,
    input  logic                 c_req,
    input  logic [3:0]           c_row,
    output logic                 c_gnt,
    output logic                 c_valid,
    output logic [ROW_WIDTH-1:0] c_data,
    output logic                 c_oob,
    output logic [3:0]           rom_addr,
    input  logic [ROW_WIDTH-1:0] rom_data,
    output logic                 busy
);

    localparam logic       c_OWN_R     = 1'b0;
    localparam logic       c_OWN_C     = 1'b1;
    localparam logic [4:0] c_NUM_ROWS  = 5'(NUM_ROWS);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOOKUP = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_last_gnt;
    logic                   r_owner_q;
    logic [3:0]             r_row_q;
    logic                   w_r_gnt;
    logic                   w_c_gnt;
    logic                   w_oob;
    logic [ROW_WIDTH-1:0]   w_lookup_data;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grants are suppressed while Reset is high so reset always beats a request.
    always_comb begin
        w_state_next = r_state;
        w_r_gnt      = 1'b0;
        w_c_gnt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!Reset) begin
                    w_r_gnt = r_req && (!c_req || (r_last_gnt == c_OWN_C));
                    w_c_gnt = c_req && (!r_req || (r_last_gnt == c_OWN_R));
                    if (w_r_gnt || w_c_gnt) begin
                        w_state_next = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign r_gnt         = w_r_gnt;
    assign c_gnt         = w_c_gnt;
    assign busy          = (r_state == S_LOOKUP);
    assign rom_addr      = (r_state == S_LOOKUP) ? r_row_q : 4'd0;
    assign w_oob         = ({1'b0, r_row_q} >= c_NUM_ROWS);
    assign w_lookup_data = w_oob ? '0 : rom_data;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_last_gnt <= c_OWN_C;
            r_owner_q  <= c_OWN_R;
            r_row_q    <= 4'd0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_oob      <= 1'b0;
            c_valid    <= 1'b0;
            c_data     <= '0;
            c_oob      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            c_valid <= 1'b0;
            if (w_r_gnt || w_c_gnt) begin
                r_row_q    <= w_r_gnt ? r_row : c_row;
                r_owner_q  <= w_c_gnt;
                r_last_gnt <= w_c_gnt;
            end
            // Only the owner's result registers move; the other side holds.
            if (r_state == S_LOOKUP) begin
                if (r_owner_q == c_OWN_R) begin
                    r_valid <= 1'b1;
                    r_data  <= w_lookup_data;
                    r_oob   <= w_oob;
                end else begin
                    c_valid <= 1'b1;
                    c_data  <= w_lookup_data;
                    c_oob   <= w_oob;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_level_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_level_rom_arbiter
// Description : Directed bench for level_rom_arbiter with a cycle-stamped model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_level_rom_arbiter;

    logic       Clk;
    logic       Reset;
    logic       r_req, c_req;
    logic [3:0] r_row, c_row;
    logic       r_gnt, r_valid, r_oob;
    logic       c_gnt, c_valid, c_oob;
    logic [9:0] r_data, c_data;
    logic [3:0] rom_addr;
    logic [9:0] rom_data;
    logic       busy;

    logic [9:0] rom_img [0:15];
    int         checks = 0;
    int         errors = 0;

    level_rom_arbiter #(.NUM_ROWS(11), .ROW_WIDTH(10)) dut (
        .Clk(Clk), .Reset(Reset),
        .r_req(r_req), .r_row(r_row), .r_gnt(r_gnt), .r_valid(r_valid),
        .r_data(r_data), .r_oob(r_oob),
        .c_req(c_req), .c_row(c_row), .c_gnt(c_gnt), .c_valid(c_valid),
        .c_data(c_data), .c_oob(c_oob),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    assign rom_data = rom_img[rom_addr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: every access is a pair of time stamps (lookup cycle, valid
    // cycle); outputs of cycle n are whatever those stamps say for n.
    // ------------------------------------------------------------------
    int         cyc = 0;
    bit         model_ok = 1'b0;
    int         look_cyc = -1, vr_cyc = -1, vc_cyc = -1;
    int         pend_row = 0, pend_owner = 0;
    int         last_owner = 1;
    int         m_r_data = 0, m_r_oob = 0, m_c_data = 0, m_c_oob = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        bit e_busy, e_rg, e_cg;
        int own, d, o;
        e_busy = (look_cyc == cyc);
        e_rg   = 1'b0;
        e_cg   = 1'b0;
        if (!Reset && !e_busy) begin
            if (r_req && c_req) begin
                e_rg = (last_owner == 1);
                e_cg = (last_owner == 0);
            end else begin
                e_rg = r_req;
                e_cg = c_req;
            end
        end
        if (model_ok) begin
            chk("r_gnt",    int'(r_gnt),    int'(e_rg));
            chk("c_gnt",    int'(c_gnt),    int'(e_cg));
            chk("busy",     int'(busy),     int'(e_busy));
            chk("rom_addr", int'(rom_addr), e_busy ? pend_row : 0);
            chk("r_valid",  int'(r_valid),  int'(vr_cyc == cyc));
            chk("c_valid",  int'(c_valid),  int'(vc_cyc == cyc));
            chk("r_data",   int'(r_data),   m_r_data);
            chk("r_oob",    int'(r_oob),    m_r_oob);
            chk("c_data",   int'(c_data),   m_c_data);
            chk("c_oob",    int'(c_oob),    m_c_oob);
        end
        if (Reset) begin
            look_cyc = -1; vr_cyc = -1; vc_cyc = -1;
            last_owner = 1;
            m_r_data = 0; m_r_oob = 0; m_c_data = 0; m_c_oob = 0;
            model_ok = 1'b1;
        end else begin
            if (e_busy) begin
                o = (pend_row >= 11) ? 1 : 0;
                d = o ? 0 : int'(rom_img[pend_row]);
                if (pend_owner == 0) begin
                    m_r_data = d; m_r_oob = o; vr_cyc = cyc + 1;
                end else begin
                    m_c_data = d; m_c_oob = o; vc_cyc = cyc + 1;
                end
            end
            if (e_rg || e_cg) begin
                own        = e_cg ? 1 : 0;
                pend_owner = own;
                pend_row   = own ? int'(c_row) : int'(r_row);
                last_owner = own;
                look_cyc   = cyc + 1;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic look();
        @(negedge Clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rom_img[0]  = 10'b1111111111; rom_img[1]  = 10'b1000000001;
        rom_img[2]  = 10'b1000110001; rom_img[3]  = 10'b0000111000;
        rom_img[4]  = 10'b1001000011; rom_img[5]  = 10'b1000000111;
        rom_img[6]  = 10'b1011100001; rom_img[7]  = 10'b1100000001;
        rom_img[8]  = 10'b1000011101; rom_img[9]  = 10'b1000000001;
        rom_img[10] = 10'b1111111111; rom_img[11] = 10'b1010101010;
        rom_img[12] = 10'b0101010101; rom_img[13] = 10'b1110001110;
        rom_img[14] = 10'b0011001100; rom_img[15] = 10'b1111100000;
        Reset = 1'b1; r_req = 1'b0; c_req = 1'b0; r_row = 4'd0; c_row = 4'd0;
        repeat (3) tick();

        // Single renderer access, row 3
        Reset = 1'b0;
        look();
        chk("lit_reset_busy", int'(busy), 0);
        chk("lit_reset_rdata", int'(r_data), 0);
        tick(); r_req = 1'b1; r_row = 4'd3;
        look(); chk("lit_t1_gnt", int'(r_gnt), 1);
        tick(); r_req = 1'b0;
        look(); chk("lit_t1_busy", int'(busy), 1); chk("lit_t1_addr", int'(rom_addr), 3);
        tick();
        look();
        chk("lit_t1_valid", int'(r_valid), 1);
        chk("lit_t1_data", int'(r_data), int'(10'b0000111000));
        chk("lit_t1_oob", int'(r_oob), 0);
        chk("lit_t1_cvalid", int'(c_valid), 0);

        // Contention from a fresh reset: R, C, R, C
        tick(); Reset = 1'b1;
        tick(); Reset = 1'b0; r_req = 1'b1; r_row = 4'd0; c_req = 1'b1; c_row = 4'd7;
        for (int i = 0; i < 8; i++) begin
            look();
            chk("lit_alt_rgnt", int'(r_gnt), (i % 4 == 0) ? 1 : 0);
            chk("lit_alt_cgnt", int'(c_gnt), (i % 4 == 2) ? 1 : 0);
            if (i >= 2 && i % 2 == 0)
                chk("lit_alt_valid", int'(r_valid | c_valid), 1);
            tick();
        end
        r_req = 1'b0; c_req = 1'b0;
        look();
        chk("lit_alt_rdata", int'(r_data), int'(10'b1111111111));
        chk("lit_alt_cdata", int'(c_data), int'(10'b1100000001));
        repeat (2) tick();

        // Out-of-range then last legal row on the collision port
        c_req = 1'b1; c_row = 4'd12;
        tick(); c_req = 1'b0;
        tick();
        look(); chk("lit_oob_valid", int'(c_valid), 1);
        chk("lit_oob_data", int'(c_data), 0); chk("lit_oob_flag", int'(c_oob), 1);
        tick(); c_req = 1'b1; c_row = 4'd10;
        tick(); c_req = 1'b0;
        tick();
        look(); chk("lit_r10_data", int'(c_data), int'(10'b1111111111));
        chk("lit_r10_oob", int'(c_oob), 0);

        // Renderer request raised during a collision lookup
        tick(); c_req = 1'b1; c_row = 4'd5;
        tick(); c_req = 1'b0; r_req = 1'b1; r_row = 4'd2;
        look(); chk("lit_wait_nognt", int'(r_gnt), 0);
        tick();
        look(); chk("lit_wait_gnt", int'(r_gnt), 1);
        tick(); r_req = 1'b0;
        tick();
        look(); chk("lit_wait_valid", int'(r_valid), 1);
        chk("lit_wait_data", int'(r_data), int'(10'b1000110001));

        // Reset during a renderer lookup
        tick(); r_req = 1'b1; r_row = 4'd4;
        tick(); Reset = 1'b1;
        tick(); Reset = 1'b0;
        look();
        chk("lit_rst_valid", int'(r_valid), 0);
        chk("lit_rst_data", int'(r_data), 0);
        chk("lit_rst_cdata", int'(c_data), 0);
        chk("lit_rst_busy", int'(busy), 0);
        chk("lit_rst_regnt", int'(r_gnt), 1);
        tick(); r_req = 1'b0;
        tick();
        look(); chk("lit_rst_data2", int'(r_data), int'(10'b1001000011));

        // Full row sweep on the renderer
        for (int row = 0; row < 16; row++) begin
            tick(); r_req = 1'b1; r_row = 4'(row);
            tick(); r_req = 1'b0;
            tick();
            look();
            chk("lit_sweep_valid", int'(r_valid), 1);
            chk("lit_sweep_data", int'(r_data), (row < 11) ? int'(rom_img[row]) : 0);
            chk("lit_sweep_oob", int'(r_oob), (row < 11) ? 0 : 1);
        end
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
